wb_regfile: RTL

- Write-back end of the execute-stage result interface: accepts {wd, wreg, wdata} results and commits them to the 32x32 general register file.
- Results are decoupled through a 2-entry in-order commit buffer, so a commit stall does not block execute until the buffer fills.
- Provides the two decode-stage read ports. Reads bypass pending buffered writes, so decode always sees the architecturally newest value.
- Register 0 is hardwired to zero.

---
 rtl/wb_regfile_pkg.sv | 21 ++
 rtl/wb_regfile_if.sv | 21 ++
 rtl/wb_commit_buf.sv | 78 +++++++
 rtl/wb_regfile.sv | 78 +++++++
 4 files changed

// File: rtl/wb_regfile_pkg.sv
// Shared widths, constants and the commit-buffer entry type.
// Imported by the write-back register file and its commit buffer.
package wb_regfile_pkg;
  localparam int RegBus     = 32;
  localparam int RegAddrBus = 5;
  localparam int RegNum     = 32;
  localparam int Depth      = 2;

  localparam logic RstEnable = 1'b0;

  typedef logic [RegBus-1:0]     reg_t;
  typedef logic [RegAddrBus-1:0] addr_t;

  localparam reg_t  ZeroWord   = '0;
  localparam addr_t NopRegAddr = '0;

  typedef struct packed {
    addr_t wd;
    reg_t  data;
  } wb_ent_t;
endpackage

// File: rtl/wb_regfile_if.sv
// Execute-result handshake: {wd, wreg, wdata} offered with valid/ready.
// master = execute producer, slave = write-back register file.
interface wb_regfile_if;
  import wb_regfile_pkg::*;

  logic  valid;
  logic  ready;
  logic  wreg;
  addr_t wd;
  reg_t  wdata;

  modport master (
    output valid, wd, wreg, wdata,
    input  ready
  );

  modport slave (
    input  valid, wd, wreg, wdata,
    output ready
  );
endinterface

// File: rtl/wb_commit_buf.sv
// 2-entry in-order commit buffer with newest-first lookup for two ports.
// Ports: push/ent in, pop request, ready/count, head commit out, lookups.
module wb_commit_buf
  import wb_regfile_pkg::*;
#(
  parameter int DEPTH = Depth
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    push_i,
  input  wb_ent_t ent_i,
  input  logic    pop_i,
  output logic    ready_o,
  output logic [1:0] count_o,
  output logic    cm_we_o,
  output wb_ent_t cm_ent_o,
  input  addr_t   raddr1_i,
  output logic    hit1_o,
  output reg_t    hdata1_o,
  input  addr_t   raddr2_i,
  output logic    hit2_o,
  output reg_t    hdata2_o
);

  wb_ent_t    slot_q [2];
  wb_ent_t    slot_d [2];
  logic [1:0] count_q, count_d;
  logic       ready_q, ready_d;
  logic       pop;

  assign pop = pop_i && (count_q != 2'd0);

  // Slot 0 is always the head; a pop shifts slot 1 down, then a push
  // lands in the first free slot behind whatever survived.
  always_comb begin
    slot_d  = slot_q;
    count_d = count_q;
    if (pop) begin
      slot_d[0] = slot_q[1];
      count_d   = count_q - 2'd1;
    end
    if (push_i) begin
      slot_d[count_d[0]] = ent_i;
      count_d            = count_d + 2'd1;
    end
    ready_d = (count_d != 2'(DEPTH));
  end

  always_ff @(posedge clk) begin
    if (rst_n == RstEnable) begin
      count_q <= 2'd0;
      ready_q <= 1'b1;
      slot_q  <= '{default: '0};
    end else begin
      count_q <= count_d;
      ready_q <= ready_d;
      slot_q  <= slot_d;
    end
  end

  // Tail is checked before head so duplicates return the newest value.
  function automatic logic [RegBus:0] look(addr_t a);
    if (count_q == 2'd2 && slot_q[1].wd == a)
      return {1'b1, slot_q[1].data};
    if (count_q != 2'd0 && slot_q[0].wd == a)
      return {1'b1, slot_q[0].data};
    return {1'b0, ZeroWord};
  endfunction

  assign {hit1_o, hdata1_o} = look(raddr1_i);
  assign {hit2_o, hdata2_o} = look(raddr2_i);

  assign ready_o  = ready_q;
  assign count_o  = count_q;
  assign cm_we_o  = pop;
  assign cm_ent_o = slot_q[0];

endmodule

// File: rtl/wb_regfile.sv
// Write-back register file: buffers execute results, commits in order.
// Ports: clk/rst_n, result bus (slave), commit_en, 2 read ports, count.
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int DATA_W = RegBus,
  parameter int ADDR_W = RegAddrBus,
  parameter int NREGS  = RegNum,
  parameter int DEPTH  = Depth
) (
  input  logic              clk,
  input  logic              rst_n,
  wb_regfile_if.slave       res,
  input  logic              commit_en_i,
  input  logic              re1_i,
  input  logic [ADDR_W-1:0] raddr1_i,
  output logic [DATA_W-1:0] rdata1_o,
  input  logic              re2_i,
  input  logic [ADDR_W-1:0] raddr2_i,
  output logic [DATA_W-1:0] rdata2_o,
  output logic [1:0]        count_o
);

  logic [DATA_W-1:0] rf_q [NREGS];

  logic    push;
  wb_ent_t ent;
  logic    cm_we;
  wb_ent_t cm_ent;
  logic    hit1, hit2;
  reg_t    hd1, hd2;

  // Results with no destination, or aimed at r0, complete the handshake
  // but never occupy a buffer slot.
  assign push = res.valid && res.ready && res.wreg &&
                (res.wd != NopRegAddr);
  assign ent  = '{wd: res.wd, data: res.wdata};

  wb_commit_buf #(.DEPTH(DEPTH)) u_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .push_i   (push),
    .ent_i    (ent),
    .pop_i    (commit_en_i),
    .ready_o  (res.ready),
    .count_o  (count_o),
    .cm_we_o  (cm_we),
    .cm_ent_o (cm_ent),
    .raddr1_i (raddr1_i),
    .hit1_o   (hit1),
    .hdata1_o (hd1),
    .raddr2_i (raddr2_i),
    .hit2_o   (hit2),
    .hdata2_o (hd2)
  );

  always_ff @(posedge clk) begin
    if (rst_n == RstEnable) begin
      for (int i = 0; i < NREGS; i++)
        rf_q[i] <= ZeroWord;
    end else if (cm_we) begin
      rf_q[cm_ent.wd] <= cm_ent.data;
    end
  end

  always_comb begin
    rdata1_o = ZeroWord;
    if (rst_n != RstEnable && re1_i && raddr1_i != NopRegAddr)
      rdata1_o = hit1 ? hd1 : rf_q[raddr1_i];
  end

  always_comb begin
    rdata2_o = ZeroWord;
    if (rst_n != RstEnable && re2_i && raddr2_i != NopRegAddr)
      rdata2_o = hit2 ? hd2 : rf_q[raddr2_i];
  end

endmodule
